spi_cmd_ctrl: RTL
=================

SPI_CMD_CTRL -- requirements
Module: spi_cmd_ctrl

Interface
REQ-001 Parameter: NUM_REGS, 16, number of implemented registers (1..64); addresses 0..NUM_REGS-1 valid.
REQ-002 sclk  in  1  clock; all state on posedge sclk.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 cs_n  in  1  frame select, active-low; high = no frame.
REQ-005 rx_valid  in  1  one-cycle pulse, rx_byte holds a complete received byte.
REQ-006 rx_byte  in  8  received byte, valid with rx_valid.
REQ-007 tx_byte  out  8  byte to shift out on the next SPI byte slot.
REQ-008 reg_addr  out  6  register address.
REQ-009 reg_wdata  out  8  write data.
REQ-010 reg_we  out  1  one-cycle write strobe.
REQ-011 reg_re  out  1  one-cycle read strobe.
REQ-012 reg_rdata  in  8  combinational read data for reg_addr, sampled in the reg_re cycle.
REQ-013 err  out  1  sticky: access to address >= NUM_REGS since last status read.
REQ-014 frame_done  out  1  one-cycle pulse on first posedge sclk after cs_n rises past a completed command.

Function
REQ-015 Command byte = first byte of frame: bit7 W(1)/R(0), bit6 burst, bits5:0 start address.
REQ-016 FSM states: CMD, WR_DATA, RD_DATA, DRAIN; cs_n high asynchronously forces CMD (registers, err, tx_byte preserved).
REQ-017 CMD + rx_valid: latch address/mode; W -> WR_DATA; R -> RD_DATA with reg_re pulsed next cycle and tx_byte <= reg_rdata the following edge.
REQ-018 While in CMD, tx_byte SHALL hold status {1'b1, err, 6'd0}; err clears when a command byte is accepted after status was loaded.
REQ-019 WR_DATA + rx_valid: next cycle reg_we=1, reg_wdata=rx_byte, reg_addr=current address.
REQ-020 RD_DATA + rx_valid (MOSI byte ignored): address advances, reg_re pulsed next cycle, tx_byte updated one cycle after reg_re.
REQ-021 Burst=1: address increments after each data byte, wrapping NUM_REGS-1 -> 0.
REQ-022 Burst=0: after first data byte go to DRAIN; further bytes ignored, no strobes, tx_byte=8'h00.
REQ-023 Address >= NUM_REGS: write suppressed, read returns 8'h00, reg_re not pulsed, err set.
REQ-024 rx_valid while cs_n high ignored; rx_valid pulses spaced >= 2 cycles guaranteed by source.
REQ-025 reg_we and reg_re never both high; each strictly one cycle wide.
REQ-026 cs_n rising mid-byte or mid-burst: no partial write; pending strobe not issued.

Reset
REQ-027 rst_n low: state CMD, tx_byte=8'h80, reg_addr=0, reg_wdata=0, reg_we=0, reg_re=0, err=0, frame_done=0.
REQ-028 Reset deassertion needs no sclk edges to take effect; first frame after reset fully functional.

Structure
REQ-029 Shared package holds FSM state encoding, command bit positions, STATUS_READY constant 8'h80.
REQ-030 Single module, no sub-module; address-increment/range check inline.
REQ-031 All outputs registered.

Verification
REQ-032 Write single: cmd 8'h83, data 8'h5A -> one reg_we, addr 3, wdata 8'h5A; extra byte 8'hFF ignored.
REQ-033 Burst read: cmd 8'h4E (NUM_REGS=16), three dummies -> reg_re at 14, 15, 0; tx_byte follows reg_rdata.
REQ-034 Out-of-range: cmd 8'h94, data 8'h11 -> no reg_we; next frame status byte 8'hC0, then 8'h80.
REQ-035 cs_n rises after 4 bits of data byte -> no reg_we, FSM in CMD, frame_done pulses once.
REQ-036 rst_n asserted mid-burst -> all outputs to reset values immediately, tx_byte 8'h80.

Source files
------------

// File: rtl/spi_cmd_ctrl_pkg.sv
// Shared definitions for the SPI command controller: FSM encoding, command byte
// field positions and the status byte seen by the host between commands.
package spi_cmd_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_CMD     = 2'd0,
        ST_WR_DATA = 2'd1,
        ST_RD_DATA = 2'd2,
        ST_DRAIN   = 2'd3
    } state_t;

    localparam int CMD_WRITE_BIT = 7;
    localparam int CMD_BURST_BIT = 6;
    localparam int CMD_ADDR_MSB  = 5;

    localparam logic [7:0] STATUS_READY = 8'h80;

    // Status byte: ready flag in bit 7, sticky error flag in bit 6.
    function automatic logic [7:0] statusByte(input logic errFlag);
        return STATUS_READY | {1'b0, errFlag, 6'd0};
    endfunction

endpackage

// File: rtl/spi_cmd_ctrl.sv
// SPI command decoder: the first byte of each frame selects read/write, burst mode
// and a start address; following bytes are written to or prefetched from registers.
import spi_cmd_ctrl_pkg::*;

module spi_cmd_ctrl #(
    parameter int NUM_REGS = 16
) (
    input  logic       sclk,
    input  logic       rst_n,
    input  logic       cs_n,
    input  logic       rx_valid,
    input  logic [7:0] rx_byte,
    output logic [7:0] tx_byte,
    output logic [5:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata,
    output logic       err,
    output logic       frame_done
);

    state_t     r_state;
    logic [5:0] r_addr;
    logic       r_burst;
    logic       r_zeroLoad;
    logic       r_cmdSeen;
    logic       r_errShown;

    logic       w_accept;
    logic [5:0] w_cmdAddr;
    logic [5:0] w_nextAddr;
    logic       w_cmdInRange;
    logic       w_curInRange;
    logic       w_nextInRange;

    function automatic logic inRange(input logic [5:0] a);
        return {1'b0, a} < 7'(NUM_REGS);
    endfunction

    assign w_accept      = rx_valid & ~cs_n;
    assign w_cmdAddr     = rx_byte[CMD_ADDR_MSB:0];
    assign w_nextAddr    = ({1'b0, r_addr} == 7'(NUM_REGS - 1)) ? 6'd0 : r_addr + 6'd1;
    assign w_cmdInRange  = inRange(w_cmdAddr);
    assign w_curInRange  = inRange(r_addr);
    assign w_nextInRange = inRange(w_nextAddr);

    // cs_n high clears the FSM and any strobe in flight, so an aborted frame never
    // issues a late write or read.
    always_ff @(posedge sclk or negedge rst_n or posedge cs_n) begin
        if (!rst_n) begin
            r_state    <= ST_CMD;
            reg_we     <= 1'b0;
            reg_re     <= 1'b0;
            r_zeroLoad <= 1'b0;
        end else if (cs_n) begin
            r_state    <= ST_CMD;
            reg_we     <= 1'b0;
            reg_re     <= 1'b0;
            r_zeroLoad <= 1'b0;
        end else begin
            reg_we     <= 1'b0;
            reg_re     <= 1'b0;
            r_zeroLoad <= 1'b0;
            if (rx_valid) begin
                case (r_state)
                    ST_CMD: begin
                        if (rx_byte[CMD_WRITE_BIT]) begin
                            r_state <= ST_WR_DATA;
                        end else begin
                            r_state    <= ST_RD_DATA;
                            reg_re     <= w_cmdInRange;
                            r_zeroLoad <= ~w_cmdInRange;
                        end
                    end
                    ST_WR_DATA: begin
                        reg_we <= w_curInRange;
                        if (!r_burst) r_state <= ST_DRAIN;
                    end
                    ST_RD_DATA: begin
                        if (r_burst) begin
                            reg_re     <= w_nextInRange;
                            r_zeroLoad <= ~w_nextInRange;
                        end else begin
                            r_state <= ST_DRAIN;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Datapath keeps address, error and tx byte across frames; only rst_n clears it.
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr     <= 6'd0;
            r_burst    <= 1'b0;
            r_cmdSeen  <= 1'b0;
            r_errShown <= 1'b0;
            reg_addr   <= 6'd0;
            reg_wdata  <= 8'h00;
            err        <= 1'b0;
            tx_byte    <= STATUS_READY;
            frame_done <= 1'b0;
        end else begin
            frame_done <= cs_n & r_cmdSeen;
            if (cs_n) r_cmdSeen <= 1'b0;
            r_errShown <= (r_state == ST_CMD) & err;

            if (reg_re) begin
                tx_byte <= reg_rdata;
            end else if (r_zeroLoad || r_state == ST_DRAIN) begin
                tx_byte <= 8'h00;
            end else if (r_state == ST_CMD) begin
                tx_byte <= statusByte(err);
            end

            if (w_accept) begin
                case (r_state)
                    ST_CMD: begin
                        r_addr    <= w_cmdAddr;
                        r_burst   <= rx_byte[CMD_BURST_BIT];
                        r_cmdSeen <= 1'b1;
                        // Error clears only once the host has had a chance to see it.
                        if (r_errShown) err <= 1'b0;
                        if (!rx_byte[CMD_WRITE_BIT]) begin
                            reg_addr <= w_cmdAddr;
                            if (!w_cmdInRange) err <= 1'b1;
                        end
                    end
                    ST_WR_DATA: begin
                        reg_addr <= r_addr;
                        if (w_curInRange) reg_wdata <= rx_byte;
                        else err <= 1'b1;
                        if (r_burst) r_addr <= w_nextAddr;
                    end
                    ST_RD_DATA: begin
                        if (r_burst) begin
                            r_addr   <= w_nextAddr;
                            reg_addr <= w_nextAddr;
                            if (!w_nextInRange) err <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
